// File: rtl/ifetch_unit.sv
// Instruction fetch stage with a direct-mapped, one-word-per-line instruction cache.
// Holds the fetch PC. On a cache hit it pushes {instruction, PC} into the instruction
// queue. On a miss it issues one aligned word request to memory and refills the line.
// A jump retargets the PC. A jump taken during a miss does not cancel the outstanding fill.
//
// Ports:
//   clk, reset      rising-edge clock; synchronous active-high reset
//   rdy_i           global enable; 0 freezes all state and suppresses push
//   jump_i/jump_pc_i  one-cycle redirect request and its word-aligned target
//   q_full_i        instruction queue full
//   push_o, push_ins_o, push_pc_o  combinational push strobe, instruction and PC
//   mem_req_o, mem_addr_o          registered word request, held until mem_valid_i
//   mem_valid_i, mem_data_i        one-cycle word return
module ifetch_unit #(
  parameter int unsigned ICACHE_IDX = 6,
  parameter logic [31:0] RESET_PC   = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rdy_i,
  input  logic        jump_i,
  input  logic [31:0] jump_pc_i,
  input  logic        q_full_i,
  output logic        push_o,
  output logic [31:0] push_ins_o,
  output logic [31:0] push_pc_o,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_valid_i,
  input  logic [31:0] mem_data_i
);

  localparam int unsigned Lines = 2 ** ICACHE_IDX;
  localparam int unsigned TagW  = 30 - ICACHE_IDX;

  localparam logic [0:0] StIdle    = 1'b0;
  localparam logic [0:0] StWaitMem = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        mem_req_q, mem_req_d;
  logic [31:0] mem_addr_q, mem_addr_d;
  logic [31:0] fill_addr_q, fill_addr_d;

  logic [Lines-1:0] valid_q;
  logic [TagW-1:0]  tag_q  [Lines];
  logic [31:0]      data_q [Lines];

  logic [ICACHE_IDX-1:0] idx;
  logic [ICACHE_IDX-1:0] fill_idx;
  logic [TagW-1:0]       tag;
  logic                  hit;
  logic                  fill_we;

  assign idx      = pc_q[ICACHE_IDX+1:2];
  assign tag      = pc_q[31:ICACHE_IDX+2];
  assign fill_idx = fill_addr_q[ICACHE_IDX+1:2];
  assign hit      = valid_q[idx] && (tag_q[idx] == tag);
  // The fill lands at fill_addr, not at pc, so a jump during the miss cannot misplace it.
  assign fill_we  = !reset && rdy_i && (state_q == StWaitMem) && mem_valid_i;

  assign mem_req_o  = mem_req_q;
  assign mem_addr_o = mem_addr_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    fill_addr_d = fill_addr_q;
    push_o      = 1'b0;
    push_ins_o  = data_q[idx];
    push_pc_o   = pc_q;
    if (!reset && rdy_i) begin
      case (state_q)
        StIdle: begin
          if (jump_i) begin
            pc_d = jump_pc_i;
          end else if (hit) begin
            // A hit with the queue full simply holds; it never turns into a request.
            if (!q_full_i) begin
              push_o = 1'b1;
              pc_d   = pc_q + 32'd4;
            end
          end else begin
            mem_req_d   = 1'b1;
            mem_addr_d  = {pc_q[31:2], 2'b00};
            fill_addr_d = {pc_q[31:2], 2'b00};
            state_d     = StWaitMem;
          end
        end
        StWaitMem: begin
          if (mem_valid_i) begin
            mem_req_d = 1'b0;
            state_d   = StIdle;
          end
          if (jump_i) begin
            pc_d = jump_pc_i;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      pc_q        <= RESET_PC;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= 32'h0;
      fill_addr_q <= 32'h0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      fill_addr_q <= fill_addr_d;
      if (fill_we) begin
        valid_q[fill_idx] <= 1'b1;
      end
    end
  end

  // Tag and data arrays need no reset; valid_q guards them.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_q[fill_idx]  <= fill_addr_q[31:ICACHE_IDX+2];
      data_q[fill_idx] <= mem_data_i;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        reset, rdy, jump, q_full, mem_valid;
  logic [31:0] jump_pc, mem_data;
  logic        push, mem_req;
  logic [31:0] push_ins, push_pc, mem_addr;

  always #5 clk = ~clk;

  ifetch_unit #(.ICACHE_IDX(6), .RESET_PC(32'h0)) dut (
    .clk        (clk),
    .reset      (reset),
    .rdy_i      (rdy),
    .jump_i     (jump),
    .jump_pc_i  (jump_pc),
    .q_full_i   (q_full),
    .push_o     (push),
    .push_ins_o (push_ins),
    .push_pc_o  (push_pc),
    .mem_req_o  (mem_req),
    .mem_addr_o (mem_addr),
    .mem_valid_i(mem_valid),
    .mem_data_i (mem_data)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: the cache is a table of which full word address each line holds.
  logic [31:0] m_pc = 32'h0, m_addr = 32'h0, m_fill = 32'h0;
  bit          m_wait = 1'b0, m_req = 1'b0;
  bit          lv [64];
  logic [31:0] la [64];
  logic [31:0] ld [64];
  bit          armed = 1'b0;
  int          resp_cnt = -1;
  int          resp_delay = 3;  // negative selects a random 1..4 cycle latency

  logic        s_push, s_req;
  logic [31:0] s_ins, s_pc, s_addr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0000_0013;
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: drive the memory response, compare outputs, advance the model.
  task automatic cycle();
    int          i, j;
    bit          hit, e_push, req_now;
    logic [31:0] e_ins;
    if (reset) begin
      mem_valid = 1'b0;
    end else begin
      if (m_req && resp_cnt < 0)
        resp_cnt = (resp_delay < 0) ? int'($urandom_range(1, 4)) : resp_delay;
      mem_valid = rdy && m_req && (resp_cnt == 0);
    end
    mem_data = mem_valid ? mem_word(m_fill) : $urandom;
    @(negedge clk);
    i      = int'(m_pc[7:2]);
    hit    = lv[i] && (la[i] == m_pc);
    e_push = !reset && rdy && !m_wait && !jump && hit && !q_full;
    e_ins  = ld[i];
    s_push = push; s_ins = push_ins; s_pc = push_pc; s_req = mem_req; s_addr = mem_addr;
    if (armed) begin
      chk("push", {31'h0, push}, {31'h0, e_push});
      chk("mem_req", {31'h0, mem_req}, {31'h0, m_req});
      chk("mem_addr", mem_addr, m_addr);
      if (e_push) begin
        chk("push_ins", push_ins, e_ins);
        chk("push_pc", push_pc, m_pc);
      end
    end
    req_now = m_req;
    if (reset) begin
      armed = 1'b1;
      m_pc = 32'h0; m_wait = 1'b0; m_req = 1'b0; m_addr = 32'h0; m_fill = 32'h0;
      for (int k = 0; k < 64; k++) lv[k] = 1'b0;
      resp_cnt = -1;
    end else if (rdy) begin
      if (!m_wait) begin
        if (jump) m_pc = jump_pc;
        else if (hit) begin
          if (!q_full) m_pc = m_pc + 32'd4;
        end else begin
          m_req = 1'b1; m_addr = {m_pc[31:2], 2'b00}; m_fill = m_addr; m_wait = 1'b1;
        end
      end else begin
        if (mem_valid) begin
          j = int'(m_fill[7:2]);
          lv[j] = 1'b1; la[j] = m_fill; ld[j] = mem_data;
          m_req = 1'b0; m_wait = 1'b0;
        end
        if (jump) m_pc = jump_pc;
      end
      if (mem_valid) resp_cnt = -1;
      else if (req_now && resp_cnt > 0) resp_cnt--;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 100; k++) if (m_wait) cycle();
    chk("wait_idle_bound", {31'h0, m_wait}, 32'h0);
  endtask

  task automatic do_jump(input logic [31:0] tgt);
    jump = 1'b1; jump_pc = tgt;
    cycle();
    jump = 1'b0;
  endtask

  initial begin
    reset = 1'b1; rdy = 1'b1; jump = 1'b0; jump_pc = 32'h0; q_full = 1'b0;
    mem_valid = 1'b0; mem_data = 32'h0;
    #1;
    cycle(); cycle();
    reset = 1'b0;

    // Cold start: miss at 0, word returns 3 cycles after the request.
    cycle();
    cycle();
    chk("cold_req", {31'h0, s_req}, 32'h1);
    chk("cold_addr", s_addr, 32'h0);
    cycle(); cycle(); cycle();
    cycle();
    chk("cold_push", {31'h0, s_push}, 32'h1);
    chk("cold_ins", s_ins, 32'h0000_0013);
    chk("cold_pc", s_pc, 32'h0);
    chk("model_pc_after_cold", m_pc, 32'h4);

    // Fill 0x0..0xC, then jump back and stream four hits.
    for (int k = 0; k < 100 && m_pc != 32'h10; k++) cycle();
    chk("stream_reach", m_pc, 32'h10);
    do_jump(32'h0);
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("stream_push", {31'h0, s_push}, 32'h1);
      chk("stream_pc", s_pc, 32'(k * 4));
    end

    // Queue full holds the PC at a hit.
    do_jump(32'h8);
    q_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("qfull_push", {31'h0, s_push}, 32'h0);
      chk("qfull_model_pc", m_pc, 32'h8);
    end
    q_full = 1'b0;
    cycle();
    chk("qfull_release_push", {31'h0, s_push}, 32'h1);
    chk("qfull_release_pc", s_pc, 32'h8);

    // Jump beats a hit in the same cycle.
    do_jump(32'h4);
    jump = 1'b1; jump_pc = 32'h20;
    cycle();
    jump = 1'b0;
    chk("jump_hit_push", {31'h0, s_push}, 32'h0);
    chk("jump_hit_model_pc", m_pc, 32'h20);
    cycle();
    cycle();
    chk("jump_hit_req", {31'h0, s_req}, 32'h1);
    chk("jump_hit_addr", s_addr, 32'h20);
    wait_idle();

    // Jump during a miss: the 0x40 fill still completes, fetch resumes at 0x100.
    do_jump(32'h40);
    cycle();
    cycle();
    chk("miss40_addr", s_addr, 32'h40);
    do_jump(32'h100);
    wait_idle();
    cycle();
    cycle();
    chk("redir_req", {31'h0, s_req}, 32'h1);
    chk("redir_addr", s_addr, 32'h100);
    wait_idle();
    do_jump(32'h40);
    cycle();
    chk("line40_push", {31'h0, s_push}, 32'h1);
    chk("line40_pc", s_pc, 32'h40);
    chk("line40_ins", s_ins, mem_word(32'h40));

    // Freeze during a miss.
    do_jump(32'h200);
    cycle();
    cycle();
    rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("freeze_req", {31'h0, s_req}, 32'h1);
      chk("freeze_addr", s_addr, 32'h200);
      chk("freeze_push", {31'h0, s_push}, 32'h0);
    end
    rdy = 1'b1;
    wait_idle();

    // PC wraps from 0xFFFFFFFC to 0.
    do_jump(32'hFFFF_FFFC);
    cycle();
    wait_idle();
    cycle();
    chk("wrap_push", {31'h0, s_push}, 32'h1);
    chk("wrap_pc", s_pc, 32'hFFFF_FFFC);
    chk("wrap_model_pc", m_pc, 32'h0);
    cycle();
    cycle();
    chk("wrap_req", {31'h0, s_req}, 32'h1);
    chk("wrap_addr", s_addr, 32'h0);
    wait_idle();

    // Randomized traffic against the model.
    resp_delay = -1;
    for (int n = 0; n < 3000; n++) begin
      reset  = ($urandom_range(0, 299) == 0);
      rdy    = ($urandom_range(0, 9) < 8);
      jump   = ($urandom_range(0, 9) == 0);
      q_full = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 19) == 0)
        jump_pc = 32'hFFFF_FFF0 | (32'($urandom_range(0, 3)) << 2);
      else
        jump_pc = (32'($urandom_range(0, 3)) << 12) | (32'($urandom_range(0, 127)) << 2);
      cycle();
    end
    reset = 1'b0; rdy = 1'b1; jump = 1'b0; q_full = 1'b0;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
Instruction fetch stage directly upstream of the instruction queue. It holds the architectural fetch PC and looks each PC up in a small direct-mapped instruction cache. On a hit it pushes the instruction and its PC into the queue; on a miss it requests the aligned 32-bit word from the memory controller. Redirects from branch resolution (jump) retarget the PC.

Parameters:
ICACHE_IDX, 6, index bits; ICACHE_LINES = 2**ICACHE_IDX one-word lines.
RESET_PC, 32'h0, fetch PC after reset.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
rdy  in  1  global enable; 0 freezes all state
jump  in  1  redirect request, one-cycle pulse
jump_pc  in  32  redirect target (word aligned)
q_full  in  1  instruction queue full
push  out  1  push strobe to queue (combinational)
push_ins  out  32  instruction pushed
push_pc  out  32  PC of pushed instruction
mem_req  out  1  memory word request, level until mem_valid (registered)
mem_addr  out  32  request address, low 2 bits 0 (registered)
mem_valid  in  1  requested word returned, one-cycle pulse
mem_data  in  32  returned word

Behaviour:
- Reset is synchronous, active-high; clock is clk (rising edge). On reset: pc=RESET_PC, state=IDLE, all cache valid bits=0, mem_req=0, mem_addr=0, fill_addr=0. push=0 while reset=1.
- Reset mid-miss abandons the request; the memory controller shares reset.
- Cache: index=pc[ICACHE_IDX+1:2], tag=pc[31:ICACHE_IDX+2], valid bit per line. hit = valid[idx] && tag match.
- rdy=0: no state change, push=0, mem_req/mem_addr hold. The memory controller asserts mem_valid only while rdy=1.
- States: IDLE, WAIT_MEM.
- IDLE, priority order:
  1. jump=1: push=0; pc<=jump_pc; stay IDLE.
  2. Hit and q_full=0: push=1, push_ins=cache data, push_pc=pc; pc<=pc+4, mod 2^32 (0xFFFFFFFC wraps to 0).
  3. Hit and q_full=1: push=0; hold.
  4. Miss, regardless of q_full: mem_req<=1; mem_addr<={pc[31:2],2'b00}; fill_addr<=same; state<=WAIT_MEM.
- Throughput in IDLE: one instruction per cycle while hitting and the queue is not full.
- WAIT_MEM: push=0.
  - On mem_valid: write mem_data into the line at fill_addr's index, set tag and valid (overwrites the prior line); mem_req<=0; state<=IDLE.
  - On jump: pc<=jump_pc; the outstanding fill still completes and is written to the cache at fill_addr. No abort.
  - jump and mem_valid in the same cycle: both actions occur.
- Miss latency: miss detected at cycle t, mem_req high from t+1, mem_valid at cycle m, line valid from m+1, push at m+1 at the earliest.
- Only one request is outstanding at a time. mem_addr is stable while mem_req=1.
- No self-modifying-code coherence; the cache is invalidated only by reset.

Test Plan:
- Cold start: reset, memory word at 0x0 = 0x00000013, mem_valid 3 cycles after mem_req -> mem_req=1 with mem_addr=0x0 one cycle after reset release; push=1 with push_ins=0x00000013 and push_pc=0 the cycle after mem_valid; pc becomes 4.
- Streaming hits: preload 0x0..0xC via misses, then jump_pc=0 -> four consecutive push cycles, push_pc 0,4,8,0xC.
- Queue full: hit at pc=8 with q_full=1 for 5 cycles -> push=0 and pc=8 throughout; q_full=0 -> push_pc=8 that cycle.
- Jump during miss: miss at 0x40, jump_pc=0x100 while in WAIT_MEM -> line 0x40 still filled; next request mem_addr=0x100; no push of 0x40's word.
- Jump vs hit same cycle: hit at pc=4 with jump=1, jump_pc=0x20 -> push=0; pc=0x20 next cycle.
- Freeze and wrap: rdy=0 for 4 cycles during WAIT_MEM -> mem_req and mem_addr unchanged, no push. pc=0xFFFFFFFC hit with queue not full -> pc becomes 0x0.
